// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the addi/bne subset: fetches into the instruction
// register, then drives ALU, register-write and PC controls one state at a time.
// Ports: clk/rst_n; instr_req/instr_valid/instr_rdata fetch handshake; EQ flag
// from the datapath; instr, ImmSrc, ALUsrc, ALUctrl, RegWrite, PCWrite, PCsrc
// controls; retired/retire_cnt retirement tracking; sticky illegal flag.
// Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXEC); each FETCH
// cycle without instr_valid adds one. Unsupported encodings halt until reset.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_rdata,
    input  logic             instr_valid,
    input  logic             EQ,
    output logic             instr_req,
    output logic [31:0]      instr,
    output logic             ImmSrc,
    output logic             ALUsrc,
    output logic [2:0]       ALUctrl,
    output logic             RegWrite,
    output logic             PCWrite,
    output logic             PCsrc,
    output logic             retired,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             req_q, req_d;
    logic             alusrc_q, alusrc_d;
    logic [2:0]       aluctrl_q, aluctrl_d;
    logic             regwrite_q, regwrite_d;
    logic             pcwrite_q, pcwrite_d;
    logic             bne_q, bne_d;
    logic             retired_q, retired_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;

    logic is_addi;
    logic is_bne;

    assign is_addi = (instr_q[6:0] == OP_IMM)    && (instr_q[14:12] == 3'b000);
    assign is_bne  = (instr_q[6:0] == OP_BRANCH) && (instr_q[14:12] == 3'b001);

    // Next-state and next-output logic. Control outputs are computed for the
    // state being entered so that they are registered and glitch-free in it.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_addi || is_bne) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        req_d      = (state_d == S_FETCH);
        alusrc_d   = (state_d == S_EXEC) && is_addi;
        aluctrl_d  = ((state_d == S_EXEC) && is_bne) ? 3'b001 : 3'b000;
        regwrite_d = (state_d == S_EXEC) && is_addi;
        pcwrite_d  = (state_d == S_EXEC);
        bne_d      = (state_d == S_EXEC) && is_bne;
        retired_d  = (state_d == S_EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            instr_q    <= 32'h0;
            req_q      <= 1'b1;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= 3'b000;
            regwrite_q <= 1'b0;
            pcwrite_q  <= 1'b0;
            bne_q      <= 1'b0;
            retired_q  <= 1'b0;
            cnt_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            regwrite_q <= regwrite_d;
            pcwrite_q  <= pcwrite_d;
            bne_q      <= bne_d;
            retired_q  <= retired_d;
            cnt_q      <= cnt_d;
            illegal_q  <= illegal_d;
        end
    end

    // The request register resets to 1 so it is ready the first cycle after
    // release; gating with rst_n keeps it low while reset is held.
    assign instr_req  = req_q & rst_n;
    assign instr      = instr_q;
    assign ImmSrc     = (instr_q[6:0] == OP_IMM);
    assign ALUsrc     = alusrc_q;
    assign ALUctrl    = aluctrl_q;
    assign RegWrite   = regwrite_q;
    assign PCWrite    = pcwrite_q;
    // Branch direction follows EQ live during EXEC; bne_q is only set there.
    assign PCsrc      = bne_q & ~EQ;
    assign retired    = retired_q;
    assign retire_cnt = cnt_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      instr_rdata;
    logic             instr_valid;
    logic             EQ;
    logic             instr_req;
    logic [31:0]      instr;
    logic             ImmSrc;
    logic             ALUsrc;
    logic [2:0]       ALUctrl;
    logic             RegWrite;
    logic             PCWrite;
    logic             PCsrc;
    logic             retired;
    logic [CNT_W-1:0] retire_cnt;
    logic             illegal;

    int n_asrt = 0;
    int n_fail = 0;

    localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] ADDI_X2_1  = 32'h0010_0113;
    localparam logic [31:0] BNE_X1_X2  = 32'h0020_9463;
    localparam logic [31:0] ILLEGAL_W  = 32'h0000_0033;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_rdata (instr_rdata),
        .instr_valid (instr_valid),
        .EQ          (EQ),
        .instr_req   (instr_req),
        .instr       (instr),
        .ImmSrc      (ImmSrc),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .RegWrite    (RegWrite),
        .PCWrite     (PCWrite),
        .PCsrc       (PCsrc),
        .retired     (retired),
        .retire_cnt  (retire_cnt),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled 2 time units
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called in a FETCH cycle: present a word for one cycle, land in DECODE.
    task automatic fetch_now(input logic [31:0] w);
        instr_valid = 1'b1;
        instr_rdata = w;
        step();
        instr_valid = 1'b0;
        instr_rdata = 32'hA5A5_A5A5;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_alusrc"},   32'(ALUsrc),   32'd0);
        chk({tag, "_aluctrl"},  32'(ALUctrl),  32'd0);
        chk({tag, "_regwrite"}, 32'(RegWrite), 32'd0);
        chk({tag, "_pcwrite"},  32'(PCWrite),  32'd0);
        chk({tag, "_pcsrc"},    32'(PCsrc),    32'd0);
        chk({tag, "_retired"},  32'(retired),  32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_rdata = 32'h0;
        EQ          = 1'b0;

        // Reset state
        #12;
        chk("rst_req",     32'(instr_req),  32'd0);
        chk("rst_instr",   instr,           32'h0);
        chk("rst_immsrc",  32'(ImmSrc),     32'd0);
        chk("rst_cnt",     32'(retire_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal),    32'd0);
        chk_idle("rst");

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", 32'(instr_req), 32'd1);

        // addi x1,x0,5 fetched in the first FETCH cycle
        fetch_now(ADDI_X1_5);
        chk("addi_dec_instr",  instr,          ADDI_X1_5);
        chk("addi_dec_immsrc", 32'(ImmSrc),    32'd1);
        chk("addi_dec_req",    32'(instr_req), 32'd0);
        chk_idle("addi_dec");
        step();
        chk("addi_ex_immsrc",   32'(ImmSrc),     32'd1);
        chk("addi_ex_alusrc",   32'(ALUsrc),     32'd1);
        chk("addi_ex_aluctrl",  32'(ALUctrl),    32'd0);
        chk("addi_ex_regwrite", 32'(RegWrite),   32'd1);
        chk("addi_ex_pcwrite",  32'(PCWrite),    32'd1);
        chk("addi_ex_pcsrc",    32'(PCsrc),      32'd0);
        chk("addi_ex_retired",  32'(retired),    32'd1);
        chk("addi_ex_req",      32'(instr_req),  32'd0);
        step();
        chk("addi_done_cnt", 32'(retire_cnt), 32'd1);
        chk("addi_done_req", 32'(instr_req),  32'd1);
        chk_idle("addi_done");

        // bne x1,x2,8 with EQ=0 (taken)
        EQ = 1'b0;
        fetch_now(BNE_X1_X2);
        chk("bne0_dec_immsrc", 32'(ImmSrc), 32'd0);
        step();
        chk("bne0_ex_immsrc",   32'(ImmSrc),   32'd0);
        chk("bne0_ex_alusrc",   32'(ALUsrc),   32'd0);
        chk("bne0_ex_aluctrl",  32'(ALUctrl),  32'd1);
        chk("bne0_ex_regwrite", 32'(RegWrite), 32'd0);
        chk("bne0_ex_pcwrite",  32'(PCWrite),  32'd1);
        chk("bne0_ex_pcsrc",    32'(PCsrc),    32'd1);
        chk("bne0_ex_retired",  32'(retired),  32'd1);
        step();
        chk("bne0_done_cnt", 32'(retire_cnt), 32'd2);

        // bne again with EQ=1 (not taken); EQ also tracked live within EXEC
        EQ = 1'b1;
        fetch_now(BNE_X1_X2);
        step();
        chk("bne1_ex_pcsrc",   32'(PCsrc),   32'd0);
        chk("bne1_ex_pcwrite", 32'(PCWrite), 32'd1);
        chk("bne1_ex_aluctrl", 32'(ALUctrl), 32'd1);
        EQ = 1'b0;
        #1;
        chk("bne1_ex_pcsrc_live", 32'(PCsrc), 32'd1);
        EQ = 1'b1;
        step();
        chk("bne1_done_cnt", 32'(retire_cnt), 32'd3);
        chk("bne1_done_pcsrc", 32'(PCsrc), 32'd0);

        // instr_valid low for 4 FETCH cycles; IR holds, request stays up
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall%0d_req", i),   32'(instr_req), 32'd1);
            chk($sformatf("stall%0d_instr", i), instr,          BNE_X1_X2);
            instr_rdata = 32'hFFFF_0000 | 32'(i);
            step();
        end
        fetch_now(ADDI_X2_1);
        instr_valid = 1'b1;
        instr_rdata = 32'hFFFF_FFFF;
        chk("stall_dec_instr", instr, ADDI_X2_1);
        step();
        chk("stall_ex_instr",   instr,        ADDI_X2_1);
        chk("stall_ex_retired", 32'(retired), 32'd1);
        instr_rdata = 32'hDEAD_BEEF;
        step();
        instr_valid = 1'b0;
        chk("stall_done_instr", instr,           ADDI_X2_1);
        chk("stall_done_cnt",   32'(retire_cnt), 32'd4);
        chk("stall_done_req",   32'(instr_req),  32'd1);

        // Illegal encoding halts
        fetch_now(ILLEGAL_W);
        chk("ill_dec_flag", 32'(illegal), 32'd0);
        step();
        chk("ill_halt_flag", 32'(illegal),   32'd1);
        chk("ill_halt_req",  32'(instr_req), 32'd0);
        for (int i = 0; i < 12; i++) begin
            instr_valid = 1'b1;
            instr_rdata = ADDI_X1_5;
            EQ = i[0];
            step();
            chk($sformatf("halt%0d_req", i),   32'(instr_req),  32'd0);
            chk($sformatf("halt%0d_instr", i), instr,           ILLEGAL_W);
            chk($sformatf("halt%0d_cnt", i),   32'(retire_cnt), 32'd4);
            chk_idle($sformatf("halt%0d", i));
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("halt_rst_flag",  32'(illegal),    32'd0);
        chk("halt_rst_cnt",   32'(retire_cnt), 32'd0);
        chk("halt_rst_instr", instr,           32'h0);
        chk("halt_rst_req",   32'(instr_req),  32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("halt_rel_req", 32'(instr_req), 32'd1);

        // 17 back-to-back addi with a 4-bit counter: wraps after the 16th
        for (int k = 1; k <= 17; k++) begin
            fetch_now(ADDI_X1_5);
            step();
            step();
            chk($sformatf("wrap%0d_cnt", k), 32'(retire_cnt), 32'(k % 16));
        end

        // Reset pulsed during EXEC aborts the instruction
        fetch_now(ADDI_X1_5);
        step();
        chk("abort_ex_regwrite", 32'(RegWrite), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_regwrite", 32'(RegWrite),   32'd0);
        chk("abort_pcwrite",  32'(PCWrite),    32'd0);
        chk("abort_retired",  32'(retired),    32'd0);
        chk("abort_cnt",      32'(retire_cnt), 32'd0);
        chk("abort_instr",    instr,           32'h0);
        chk("abort_req",      32'(instr_req),  32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("abort_rel_req",   32'(instr_req), 32'd1);
        chk("abort_rel_instr", instr,          32'h0);
        chk_idle("abort_rel");
        fetch_now(ADDI_X2_1);
        step();
        step();
        chk("resume_cnt", 32'(retire_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM that sequences the single shared datapath (instruction register, `sign_extend`, ALU, register file write port, PC update) for the `addi`/`bne` instruction subset. It fetches an instruction word through a valid-qualified instruction-memory handshake and latches it into the instruction register. It drives `ImmSrc` into `sign_extend` and issues the ALU, register-write and PC controls one state at a time. It also counts retired instructions and halts on any unsupported encoding.

## Interface
- `CNT_W`, 16: width of retired-instruction counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_rdata`  in  32  instruction word from instruction memory.
- `instr_valid`  in  1  `instr_rdata` valid this cycle; ignored outside FETCH.
- `EQ`  in  1  ALU equality flag (rs1 == rs2), combinational from datapath.
- `instr_req`  out  1  fetch request to instruction memory.
- `instr`  out  32  instruction register contents; feeds `sign_extend` and register-file address decode.
- `ImmSrc`  out  1  1 = `addi` immediate format, 0 = `bne` format.
- `ALUsrc`  out  1  1 = ALU operand B is `ImmOp`, 0 = rs2.
- `ALUctrl`  out  3  3'b000 add, 3'b001 sub.
- `RegWrite`  out  1  register file write enable.
- `PCWrite`  out  1  PC update enable.
- `PCsrc`  out  1  1 = PC + `ImmOp`, 0 = PC + 4.
- `retired`  out  1  one-cycle pulse per completed instruction.
- `retire_cnt`  out  `CNT_W`  count of retired instructions.
- `illegal`  out  1  sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, EXEC, HALT. Reset state is FETCH.
- FETCH
  - `instr_req` = 1.
  - While `instr_valid` = 0: stay in FETCH.
  - On `instr_valid` = 1: IR <= `instr_rdata`; go to DECODE.
- DECODE: no datapath enables.
  - Legal when opcode = 7'b0010011 with funct3 = 3'b000 (`addi`), or opcode = 7'b1100011 with funct3 = 3'b001 (`bne`).
  - Legal: go to EXEC.
  - Otherwise: set `illegal`; go to HALT.
- EXEC, `addi`: `ALUsrc`=1, `ALUctrl`=000, `RegWrite`=1, `PCWrite`=1, `PCsrc`=0.
- EXEC, `bne`: `ALUsrc`=0, `ALUctrl`=001, `RegWrite`=0, `PCWrite`=1, `PCsrc`=~`EQ`.
- EXEC, both: `retired`=1, `retire_cnt` += 1; go to FETCH.
- HALT: all enables 0, `instr_req`=0. Stays in HALT until reset.
- `ImmSrc` is decoded combinationally from IR at all times: 1 iff IR[6:0] = 7'b0010011.
- Outside EXEC, `ALUsrc`, `ALUctrl`, `RegWrite`, `PCWrite`, `PCsrc` and `retired` are all 0.
- `retire_cnt` wraps from 2^CNT_W−1 to 0 with no flag.
- `instr_valid` is ignored in DECODE, EXEC and HALT. IR is written only in FETCH.

## Timing
- Reset (`rst_n` low, asynchronous)
  - State = FETCH; IR = 0, so `instr` = 0 and `ImmSrc` = 0.
  - `retire_cnt` = 0, `illegal` = 0.
  - All enables and `retired` = 0.
  - `instr_req` is gated to 0 while `rst_n` = 0. It is 1 in the first cycle after deassertion.
- Latency with `instr_valid` in FETCH cycle n:
  - DECODE in cycle n+1.
  - EXEC in cycle n+2: register write and PC update occur at the end of n+2.
  - FETCH again in cycle n+3.
  - Minimum 3 cycles per instruction; each cycle of `instr_valid` low in FETCH adds one cycle.
- `EQ` is sampled combinationally during EXEC only. It must be stable by the EXEC clock edge.
- Reset asserted mid-instruction: the instruction is aborted with no `RegWrite` or `PCWrite` after assertion. Counter and flag clear.
- Reset from HALT returns to FETCH.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with `instr_valid` in the first FETCH cycle:
  - `instr` = 0x00500093 in DECODE.
  - EXEC in the third cycle with `ImmSrc`=1, `ALUsrc`=1, `ALUctrl`=000, `RegWrite`=1, `PCWrite`=1, `PCsrc`=0.
  - `retired` pulses; `retire_cnt`=1.
- `bne x1,x2,8` (0x00209463) with `EQ`=0 in EXEC:
  - `ImmSrc`=0, `ALUctrl`=001, `RegWrite`=0, `PCWrite`=1, `PCsrc`=1.
  - Repeat with `EQ`=1: `PCsrc`=0.
- `instr_valid` held low 4 cycles in FETCH:
  - `instr_req` stays 1 and IR is unchanged.
  - The instruction retires 7 cycles after FETCH entry.
  - A pulse on `instr_valid` during DECODE or EXEC does not alter IR.
- Illegal word 0x00000033:
  - `illegal`=1 in the cycle after DECODE; state is HALT.
  - `instr_req`=0 and no enables asserted for 10+ cycles.
  - Reset clears `illegal` and fetching resumes.
- `CNT_W`=4, 17 consecutive `addi`: `retire_cnt` reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- `rst_n` pulsed low during EXEC of `addi`:
  - `RegWrite`/`PCWrite` drop immediately; `retire_cnt`=0.
  - `instr`=0; FETCH with `instr_req`=1 in the first cycle after release.
